// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              id_alusrc;
  logic              id_regdst;
  logic [2:0]        id_aluop;
  logic              id_valid;
  logic              flush;
  logic              hold;

  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_alusrc;
  logic [2:0]        ex_aluop;
  logic              ex_valid;
  logic              pc_write;
  logic              if_id_write;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // ID stage / upstream control side
  modport master (
    output id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
           id_regdst, id_aluop, id_valid, flush, hold,
    input  ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
           ex_aluop, ex_valid, pc_write, if_id_write, stall_cnt, flush_cnt
  );

  // pipeline register side
  modport slave (
    input  id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc,
           id_regdst, id_aluop, id_valid, flush, hold,
    output ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
           ex_aluop, ex_valid, pc_write, if_id_write, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and event counters
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dst;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [2:0]        aluop;
    logic              valid;
  } ex_t;

  ex_t              ex_q;
  ex_t              id_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             load_use;

  always_comb begin
    id_d          = '0;
    id_d.rs       = bus.id_rs;
    id_d.rt       = bus.id_rt;
    id_d.dst      = bus.id_regdst ? bus.id_rd : bus.id_rt;
    id_d.rs_data  = bus.id_rs_data;
    id_d.rt_data  = bus.id_rt_data;
    id_d.imm      = bus.id_imm;
    id_d.regwrite = bus.id_regwrite;
    id_d.memread  = bus.id_memread;
    id_d.memwrite = bus.id_memwrite;
    id_d.memtoreg = bus.id_memtoreg;
    id_d.alusrc   = bus.id_alusrc;
    id_d.aluop    = bus.id_aluop;
    id_d.valid    = bus.id_valid;
  end

  // A load writing $0 produces nothing to wait for, hence the dst != 0 term.
  assign load_use = ex_q.valid & ex_q.memread & bus.id_valid & (ex_q.dst != 5'd0) &
                    ((ex_q.dst == bus.id_rs) | (ex_q.dst == bus.id_rt));

  assign bus.pc_write    = ~(load_use & ~bus.flush);
  assign bus.if_id_write = ~(load_use & ~bus.flush);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.flush) begin
      ex_q <= '0;
      if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end else if (!bus.hold) begin
      if (load_use) begin
        ex_q <= '0;
        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      end else begin
        ex_q <= id_d;
      end
    end
  end

  assign bus.ex_rs       = ex_q.rs;
  assign bus.ex_rt       = ex_q.rt;
  assign bus.ex_dst      = ex_q.dst;
  assign bus.ex_rs_data  = ex_q.rs_data;
  assign bus.ex_rt_data  = ex_q.rt_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for the ID/EX pipeline register
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [2:0]  aluop;
    logic        valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_ex(input exp_t e);
    check("ex_rs",       bus.ex_rs,       e.rs);
    check("ex_rt",       bus.ex_rt,       e.rt);
    check("ex_dst",      bus.ex_dst,      e.dst);
    check("ex_rs_data",  bus.ex_rs_data,  e.rs_data);
    check("ex_rt_data",  bus.ex_rt_data,  e.rt_data);
    check("ex_imm",      bus.ex_imm,      e.imm);
    check("ex_regwrite", bus.ex_regwrite, e.regwrite);
    check("ex_memread",  bus.ex_memread,  e.memread);
    check("ex_memwrite", bus.ex_memwrite, e.memwrite);
    check("ex_memtoreg", bus.ex_memtoreg, e.memtoreg);
    check("ex_alusrc",   bus.ex_alusrc,   e.alusrc);
    check("ex_aluop",    bus.ex_aluop,    e.aluop);
    check("ex_valid",    bus.ex_valid,    e.valid);
    check("stall_cnt",   bus.stall_cnt,   e.stall_cnt);
    check("flush_cnt",   bus.flush_cnt,   e.flush_cnt);
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic rw, input logic mr, input logic mw, input logic mtr,
                        input logic as, input logic rdst, input logic [2:0] op, input logic v);
    bus.id_rs = rs;         bus.id_rt = rt;          bus.id_rd = rd;
    bus.id_rs_data = rsd;   bus.id_rt_data = rtd;    bus.id_imm = imm;
    bus.id_regwrite = rw;   bus.id_memread = mr;     bus.id_memwrite = mw;
    bus.id_memtoreg = mtr;  bus.id_alusrc = as;      bus.id_regdst = rdst;
    bus.id_aluop = op;      bus.id_valid = v;
  endtask

  // Checks the stall outputs, predicts the next register contents, then compares after the edge.
  task automatic step();
    exp_t nx;
    exp_t e;
    logic lu;
    #1;
    lu = m.valid & m.memread & bus.id_valid & (m.dst != 5'd0) &
         ((m.dst == bus.id_rs) | (m.dst == bus.id_rt));
    check("pc_write",    bus.pc_write,    !(lu && !bus.flush));
    check("if_id_write", bus.if_id_write, !(lu && !bus.flush));
    nx = m;
    if (rst) begin
      nx = '0;
    end else if (bus.flush) begin
      nx = '0;
      nx.stall_cnt = m.stall_cnt;
      nx.flush_cnt = (m.flush_cnt == 16'hFFFF) ? m.flush_cnt : m.flush_cnt + 16'd1;
    end else if (bus.hold) begin
      nx = m;
    end else if (lu) begin
      nx = '0;
      nx.flush_cnt = m.flush_cnt;
      nx.stall_cnt = (m.stall_cnt == 16'hFFFF) ? m.stall_cnt : m.stall_cnt + 16'd1;
    end else begin
      nx.rs = bus.id_rs;             nx.rt = bus.id_rt;
      nx.dst = bus.id_regdst ? bus.id_rd : bus.id_rt;
      nx.rs_data = bus.id_rs_data;   nx.rt_data = bus.id_rt_data;   nx.imm = bus.id_imm;
      nx.regwrite = bus.id_regwrite; nx.memread = bus.id_memread;
      nx.memwrite = bus.id_memwrite; nx.memtoreg = bus.id_memtoreg;
      nx.alusrc = bus.id_alusrc;     nx.aluop = bus.id_aluop;       nx.valid = bus.id_valid;
    end
    sb_q.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_ex(e);
  endtask

  initial begin
    set_id(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m = '0;
    check("init_ex_valid", bus.ex_valid, 1'b0);
    check("init_stall_cnt", bus.stall_cnt, 16'd0);

    // pass-through, then reset pulse over non-zero contents
    set_id(5'd3, 5'd4, 5'd5, 32'hA5A5A5A5, 32'h1234_5678, 32'hFFFF_FFF0, 1, 0, 0, 0, 0, 1, 3'd2, 1);
    step();
    check("pt_ex_rs", bus.ex_rs, 5'd3);
    check("pt_ex_dst", bus.ex_dst, 5'd5);
    check("pt_ex_rs_data", bus.ex_rs_data, 32'hA5A5A5A5);
    check("pt_ex_valid", bus.ex_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ex_rs_data", bus.ex_rs_data, 32'd0);
    check("rst_pc_write", bus.pc_write, 1'b1);

    // regdst=0 selects rt as destination
    set_id(5'd7, 5'd9, 5'd11, 32'h0, 32'hDEAD_BEEF, 32'h10, 0, 0, 1, 0, 1, 0, 3'd5, 1);
    step();
    check("sw_ex_dst", bus.ex_dst, 5'd9);

    // load-use: lw $8, then add using $8
    set_id(5'd2, 5'd8, 5'd9, 32'h100, 32'h0, 32'h4, 1, 1, 0, 1, 1, 0, 3'd0, 1);
    step();
    set_id(5'd8, 5'd3, 5'd10, 32'h11, 32'h22, 32'h0, 1, 0, 0, 0, 0, 1, 3'd2, 1);
    #1;
    check("lu_pc_write", bus.pc_write, 1'b0);
    step();
    check("lu_bubble_valid", bus.ex_valid, 1'b0);
    check("lu_bubble_dst", bus.ex_dst, 5'd0);
    check("lu_stall_cnt", bus.stall_cnt, 16'd1);
    step();
    check("lu_add_rs", bus.ex_rs, 5'd8);
    check("lu_add_valid", bus.ex_valid, 1'b1);

    // load to $0 never stalls
    set_id(5'd2, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 1, 1, 0, 1, 1, 0, 3'd0, 1);
    step();
    set_id(5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 1, 3'd2, 1);
    #1;
    check("lw0_pc_write", bus.pc_write, 1'b1);
    step();
    check("lw0_stall_cnt", bus.stall_cnt, 16'd1);

    // flush beats a simultaneous load-use
    set_id(5'd2, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 1, 1, 0, 1, 1, 0, 3'd0, 1);
    step();
    set_id(5'd8, 5'd3, 5'd10, 32'h11, 32'h22, 32'h0, 1, 0, 0, 0, 0, 1, 3'd2, 1);
    bus.flush = 1'b1;
    #1;
    check("fl_pc_write", bus.pc_write, 1'b1);
    step();
    bus.flush = 1'b0;
    check("fl_flush_cnt", bus.flush_cnt, 16'd1);
    check("fl_stall_cnt", bus.stall_cnt, 16'd1);

    // hold over a pending load-use keeps contents and still freezes PC
    set_id(5'd2, 5'd8, 5'd0, 32'h200, 32'h0, 32'h8, 1, 1, 0, 1, 1, 0, 3'd0, 1);
    step();
    set_id(5'd8, 5'd3, 5'd10, 32'h33, 32'h44, 32'h0, 1, 0, 0, 0, 0, 1, 3'd2, 1);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_pc_write", bus.pc_write, 1'b0);
    end
    check("hold_ex_dst", bus.ex_dst, 5'd8);
    check("hold_ex_rs_data", bus.ex_rs_data, 32'h200);
    check("hold_stall_cnt", bus.stall_cnt, 16'd1);
    bus.hold = 1'b0;
    step();
    step();
    check("hold_rel_stall_cnt", bus.stall_cnt, 16'd2);
    check("hold_rel_ex_rs", bus.ex_rs, 5'd8);

    // flush counter saturation
    bus.flush = 1'b1;
    for (int i = 0; i < 65538; i++) step();
    check("sat_flush_cnt", bus.flush_cnt, 16'hFFFF);
    step();
    check("sat_flush_cnt_stays", bus.flush_cnt, 16'hFFFF);
    bus.flush = 1'b0;

    // random mix with small register indices to provoke hazards
    for (int i = 0; i < 200; i++) begin
      set_id(5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
             $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom_range(0, 3) != 0));
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.hold  = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
